seq_div: RTL and testbench
==========================

# seq_div

Sequential signed divider that inverts the pipelined Booth multiplier in the MACC datapath. It takes a signed product-width dividend and a signed operand-width divisor, and returns the quotient and remainder. Results truncate toward zero, matching Verilog `/` and `%`. It runs restoring division at one bit per clock behind valid/ready handshakes, and is used for normalisation and scaling after accumulation.

## Interface
- `WN`, default 16: dividend and quotient width, signed two's complement.
- `WD`, default 8: divisor and remainder width, signed two's complement.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset is asynchronous and active-low.
- `in_valid` input 1: operands valid.
- `in_ready` output 1: block can accept operands.
- `dividend` input WN: signed dividend.
- `divisor` input WD: signed divisor.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer takes the result.
- `quotient` output WN: signed quotient.
- `remainder` output WD: signed remainder; takes the dividend's sign.
- `div_zero` output 1: divisor was 0 for this result.
- `ovf` output 1: quotient was not representable (only `-2^(WN-1) / -1`).

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch `|dividend|` as WN-bit unsigned, `|divisor|` as WD-bit unsigned, and both sign bits.
  - Clear the partial remainder (WD+1 bits) and the iteration counter.
  - If divisor==0, go to DONE. Otherwise go to CALC.
- CALC (WN cycles), per cycle:
  - Shift the MSB of the dividend magnitude into the partial remainder.
  - Trial-subtract `|divisor|`.
  - If the result is ≥0, keep it and shift quotient bit 1; otherwise restore and shift 0.
  - Counter 0..WN-1; on the last iteration go to DONE.
- Entry into DONE applies the sign fix, registered:
  - quotient = −q if the signs differ, else q.
  - remainder = −r if the dividend is negative, else r.
- Divide-by-zero result:
  - `quotient` = all ones (−1).
  - `remainder` = `dividend[WD-1:0]`.
  - `div_zero`=1, `ovf`=0.
- Overflow case: dividend = −2^(WN-1) and divisor = −1.
  - `ovf`=1, `remainder`=0.
  - `quotient` is set per Configuration.
- DONE
  - `out_valid`=1; `quotient`, `remainder`, `div_zero` and `ovf` are held stable.
  - On `out_ready`, go to IDLE.
- `in_ready` is low in CALC and DONE; there is no overlap of operations.
- Remainder magnitude is always < `|divisor|` ≤ 2^(WD-1), so it fits in WD bits signed.

## Timing
- Reset values:
  - state = IDLE, `in_ready`=1, `out_valid`=0.
  - `quotient`=0, `remainder`=0, `div_zero`=0, `ovf`=0.
- Latency, with the accept edge as T:
  - Normal operation: `out_valid` rises after edge T+WN+1, i.e. 17 cycles at the defaults.
  - Divide by zero: `out_valid` rises after edge T+1.
- Output handshake:
  - The result transfers on the edge where `out_valid && out_ready`.
  - `out_valid` drops and `in_ready` rises in the next cycle.
  - Earliest next accept is one cycle after the transfer.
- Inputs are ignored outside IDLE; `in_valid` held high during CALC has no effect.
- Mid-operation `rst_n` assertion aborts immediately. All outputs take their reset values asynchronously and no partial result is emitted.
- `out_ready` high in IDLE or CALC is ignored.

## Configuration
- `SEQ_DIV_SAT_EN`
  - Defined: in the overflow case, `quotient` = 2^(WN-1)−1 (+32767 at the defaults).
  - Undefined: `quotient` wraps to −2^(WN-1) (−32768).
  - `ovf`=1 and `remainder`=0 in both builds.

## Test plan
- 1000 / 7 -> `quotient`=142, `remainder`=6, `out_valid` exactly 17 cycles after accept. Also −1000 / 7 -> −142, −6. Also 1000 / −7 -> −142, +6.
- Product round-trip: 1400 / 25 -> 56 rem 0. Also −127 / −128 -> 0 rem −127. Also −32768 / 1 -> −32768 rem 0, `ovf`=0.
- 100 / 0 -> `div_zero`=1, `quotient`=0xFFFF, `remainder`=100, `out_valid` 1 cycle after accept.
- −32768 / −1 -> `ovf`=1, `remainder`=0, `quotient`=32767 with `SEQ_DIV_SAT_EN`, −32768 without.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE -> outputs stable, `in_ready`=0, a second `in_valid` is ignored. Then `out_ready`=1 -> one transfer, `in_ready`=1 next cycle. Back-to-back ops then give correct, distinct results.
- Assert `rst_n` low at CALC iteration 8 -> all outputs at reset values immediately. After release, 50 / 3 -> 16 rem 2 with normal latency.

Source files
------------

// File: rtl/seq_div.sv
// seq_div: sequential signed divider (restoring, one quotient bit per clock).
// Quotient and remainder truncate toward zero, matching Verilog / and %.
// Optional build macro: SEQ_DIV_SAT_EN -- when defined, the overflow case
// (-2^(WN-1) / -1) saturates the quotient to 2^(WN-1)-1 instead of wrapping.
//
// Handshake: an operand pair is accepted on a rising edge where
// in_valid && in_ready; a result is transferred on a rising edge where
// out_valid && out_ready. out_valid holds, with all result outputs stable,
// until that transfer. in_ready is low from acceptance until the cycle after
// the result transfer, so operations never overlap.
module seq_div #(
    parameter int WN = 16,
    parameter int WD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WN-1:0] dividend,
    input  logic [WD-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WN-1:0] quotient,
    output logic [WD-1:0] remainder,
    output logic          div_zero,
    output logic          ovf,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CW = $clog2(WN + 1);

`ifdef SEQ_DIV_SAT_EN
    localparam logic [WN-1:0] OVF_QUOT = {1'b0, {(WN-1){1'b1}}};
`else
    localparam logic [WN-1:0] OVF_QUOT = {1'b1, {(WN-1){1'b0}}};
`endif

    localparam logic [WN-1:0] MIN_DIVIDEND = {1'b1, {(WN-1){1'b0}}};

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [WN-1:0] dvd_q;      // dividend magnitude, shifted out as quotient bits shift in
    logic [WD-1:0] dsr_q;      // divisor magnitude
    logic [WD-1:0] rem_q;      // partial remainder; always < dsr_q so WD bits suffice
    logic [WD-1:0] dlo_q;      // raw dividend low bits, returned on divide-by-zero
    logic          neg_n_q;
    logic          neg_d_q;
    logic          dz_q;
    logic          ovf_pend_q;

    logic          in_ready_q;
    logic          out_valid_q;
    logic [WN-1:0] quotient_q;
    logic [WD-1:0] remainder_q;
    logic          div_zero_q;
    logic          ovf_q;

    // The shifted partial remainder needs WD+1 bits; bit WD of the trial
    // difference is the borrow that decides the quotient bit.
    logic [WD:0]   rem_sh_d;
    logic [WD:0]   trial_d;
    logic          qbit_d;
    logic [WN-1:0] q_fix_d;
    logic [WD-1:0] r_fix_d;

    // One restoring step plus the sign fix applied once iterations finish.
    always_comb begin
        rem_sh_d = {rem_q, dvd_q[WN-1]};
        trial_d  = rem_sh_d - {1'b0, dsr_q};
        qbit_d   = ~trial_d[WD];
        q_fix_d  = (neg_n_q ^ neg_d_q) ? -dvd_q : dvd_q;
        r_fix_d  = neg_n_q ? -rem_q : rem_q;
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            dlo_q       <= '0;
            neg_n_q     <= 1'b0;
            neg_d_q     <= 1'b0;
            dz_q        <= 1'b0;
            ovf_pend_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dvd_q      <= dividend[WN-1] ? -dividend : dividend;
                        dsr_q      <= divisor[WD-1] ? -divisor : divisor;
                        neg_n_q    <= dividend[WN-1];
                        neg_d_q    <= divisor[WD-1];
                        dlo_q      <= dividend[WD-1:0];
                        dz_q       <= (divisor == '0);
                        ovf_pend_q <= (dividend == MIN_DIVIDEND) && (divisor == '1);
                        rem_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (dz_q) begin
                        // Divide by zero skips iteration entirely.
                        quotient_q  <= '1;
                        remainder_q <= dlo_q;
                        div_zero_q  <= 1'b1;
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (cnt_q == CW'(WN)) begin
                        // All quotient bits are in; register the signed result.
                        quotient_q  <= ovf_pend_q ? OVF_QUOT : q_fix_d;
                        remainder_q <= ovf_pend_q ? '0 : r_fix_d;
                        div_zero_q  <= 1'b0;
                        ovf_q       <= ovf_pend_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        rem_q <= qbit_d ? trial_d[WD-1:0] : rem_sh_d[WD-1:0];
                        dvd_q <= {dvd_q[WN-2:0], qbit_d};
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: scoreboard bench for seq_div at default widths (WN=16, WD=8).
module tb_seq_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        ovf;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit stop_ready = 0;

    // expected {ovf, div_zero, quotient, remainder}
    logic [25:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];

    seq_div #(.WN(16), .WD(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model: plain signed arithmetic with the special cases
    function automatic logic [25:0] model(input logic [15:0] a, input logic [7:0] b);
        int sa, sb, q, r;
        logic [15:0] qv;
        logic [7:0]  rv;
        logic dz, ov;
        sa = $signed(a);
        sb = $signed(b);
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            dz = 1'b1;
            qv = 16'hFFFF;
            rv = a[7:0];
        end else if (sa == -32768 && sb == -1) begin
            ov = 1'b1;
            rv = 8'd0;
`ifdef SEQ_DIV_SAT_EN
            qv = 16'h7FFF;
`else
            qv = 16'h8000;
`endif
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            qv = q[15:0];
            rv = r[7:0];
        end
        return {ov, dz, qv, rv};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // driver: wait for in_ready, present one operand pair for one accepted edge
    task automatic issue(input logic [15:0] a, input logic [7:0] b);
        int n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL issue_timeout: in_ready stayed low for %0d cycles", n);
            return;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back(model(a, b));
        lat_q.push_back((b == 8'd0) ? 1 : 17);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
            exp_q.delete();
            lat_q.delete();
        end
    endtask

    task automatic rand_op();
        logic [15:0] a;
        logic [7:0]  b;
        a = 16'($urandom);
        b = 8'($urandom);
        case ($urandom_range(0, 9))
            0: a = 16'h8000;
            1: b = 8'h00;
            2: b = 8'hFF;
            3: b = 8'h80;
            4: a = 16'($urandom_range(0, 300));
            default: ;
        endcase
        issue(a, b);
    endtask

    // monitor: acceptance times, latency on each rising out_valid, result pops
    initial begin
        logic prev_ov;
        int   a_t, l;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else begin
                if (in_valid && in_ready) acc_q.push_back(cyc + 1);
                if (out_valid && !prev_ov) begin
                    if (acc_q.size() == 0 || lat_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL latency: out_valid rose with no accepted operation");
                    end else begin
                        a_t = acc_q.pop_front();
                        l   = lat_q.pop_front();
                        check("latency", 32'(cyc - a_t), 32'(l));
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL result: unexpected output q=%0h r=%0h", quotient, remainder);
                    end else begin
                        check("result", 32'({ovf, div_zero, quotient, remainder}), 32'(exp_q.pop_front()));
                    end
                end
                prev_ov = out_valid;
            end
        end
    end

    // main stimulus
    initial begin
        logic [25:0] exp_bp;
        int n;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        #1 rst_n = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // directed cases
        issue(16'd1000, 8'd7);
        issue(-16'sd1000, 8'd7);
        issue(16'd1000, -8'sd7);
        issue(16'd1400, 8'd25);
        issue(-16'sd127, 8'h80);
        issue(16'h8000, 8'd1);
        issue(16'd100, 8'd0);
        issue(16'h8000, 8'hFF);
        for (int i = 0; i < 30; i++) rand_op();
        drain();

        // backpressure: result must hold while out_ready is low
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_bp = model(16'd1234, -8'sd9);
        issue(16'd1234, -8'sd9);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b1;
        dividend = 16'd555;
        divisor  = 8'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold", 32'({ovf, div_zero, quotient, remainder}), 32'(exp_bp));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        issue(16'd7777, 8'd33);
        issue(-16'sd300, 8'd100);
        drain();

        // abort mid-calculation with reset
        @(posedge clk); #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_div_zero", 32'(div_zero), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        acc_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        issue(16'd50, 8'd3);
        drain();

        // random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 30; i++) rand_op();
                drain();
                stop_ready = 1;
            end
            begin
                while (!stop_ready) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join

        repeat (3) @(posedge clk);
        check("queues_empty", 32'(exp_q.size() + lat_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
